// File: rtl/sipo_deserializer_pkg.sv
// Shared types and limits for the serial-in/parallel-out deserializer.
package sipo_pkg;

   localparam int SIPO_MAX_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } sipo_state_e;

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial input, parallel output and status bundle of the deserializer.
interface sipo_deserializer_if #(parameter int WIDTH = 4);

   logic             sin;
   logic             sin_en;
   logic             q_ack;
   logic [WIDTH-1:0] q;
   logic             q_valid;
   logic             busy;
   logic             overrun;
   logic             par_err;

   modport master (
      output sin, sin_en, q_ack,
      input  q, q_valid, busy, overrun, par_err
   );

   modport slave (
      input  sin, sin_en, q_ack,
      output q, q_valid, busy, overrun, par_err
   );

endinterface

// File: rtl/sipo_deserializer_bit_cnt.sv
// Data-bit counter; tc flags the last data bit so the caller can clear
// (or park at TERM) before the count could wrap.
module sipo_bit_cnt #(
   parameter int TERM = 4,
   parameter int CW   = $clog2(TERM + 1)
) (
   input  logic clk,
   input  logic rstn,
   input  logic en,
   input  logic clr,
   output logic tc
);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rstn)    cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en)  cnt <= cnt + 1'b1;
   end

   assign tc = (cnt == CW'(TERM - 1));

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel deserializer with ack handshake and sticky overrun.
// Define SIPO_DESERIALIZER_PARITY_EN to append an even-parity bit to each frame.
module sipo_deserializer
   import sipo_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1
) (
   input logic               clk,
   input logic               rstn,
   sipo_deserializer_if.slave bus
);

   if (WIDTH < 2 || WIDTH > SIPO_MAX_WIDTH) begin : g_bad_width
      $error("sipo_deserializer: WIDTH out of range");
   end

   sipo_state_e      state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_shift, word;
   logic             cnt_en, cnt_clr, tc, complete;
   logic [WIDTH-1:0] q_r;
   logic             q_valid_r, overrun_r;

   sipo_bit_cnt #(.TERM(WIDTH)) u_bit_cnt (
      .clk  (clk),
      .rstn (rstn),
      .en   (cnt_en),
      .clr  (cnt_clr),
      .tc   (tc)
   );

   always_ff @(posedge clk) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      cnt_en   = 1'b0;
      cnt_clr  = 1'b0;
      complete = 1'b0;
      case (state_q)
         IDLE, SHIFT: begin
            if (bus.sin_en) begin
               cnt_en = 1'b1;
               if (tc) begin
`ifdef SIPO_DESERIALIZER_PARITY_EN
                  state_d = PARITY;
`else
                  complete = 1'b1;
                  cnt_clr  = 1'b1;
                  state_d  = IDLE;
`endif
               end else begin
                  state_d = SHIFT;
               end
            end
         end
`ifdef SIPO_DESERIALIZER_PARITY_EN
         PARITY: begin
            if (bus.sin_en) begin
               complete = 1'b1;
               cnt_clr  = 1'b1;
               state_d  = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      if (MSB_FIRST) sr_shift = {sr_q[WIDTH-2:0], bus.sin};
      else           sr_shift = {bus.sin, sr_q[WIDTH-1:1]};
   end

   always_ff @(posedge clk) begin
      if (!rstn)       sr_q <= '0;
      else if (cnt_en) sr_q <= sr_shift;
   end

`ifdef SIPO_DESERIALIZER_PARITY_EN
   // data is already complete in sr_q when the parity bit arrives
   logic perr, par_err_r;
   assign word = sr_q;
   assign perr = ^{sr_q, bus.sin};

   always_ff @(posedge clk) begin
      if (!rstn)                            par_err_r <= 1'b0;
      else if (complete && (!q_valid_r || bus.q_ack)) par_err_r <= perr;
   end

   assign bus.par_err = par_err_r;
`else
   assign word        = sr_shift;
   assign bus.par_err = 1'b0;
`endif

   // a completed word is only taken if the previous one is gone or leaving now
   always_ff @(posedge clk) begin
      if (!rstn) begin
         q_r       <= '0;
         q_valid_r <= 1'b0;
         overrun_r <= 1'b0;
      end else if (complete) begin
         if (!q_valid_r || bus.q_ack) begin
            q_r       <= word;
            q_valid_r <= 1'b1;
         end else begin
            overrun_r <= 1'b1;
         end
      end else if (q_valid_r && bus.q_ack) begin
         q_valid_r <= 1'b0;
      end
   end

   assign bus.q       = q_r;
   assign bus.q_valid = q_valid_r;
   assign bus.overrun = overrun_r;
   assign bus.busy    = (state_q != IDLE);

endmodule
